// File: rtl/n_rd_arbiter_if.sv
// Read-port bus shared by the EVP/EVB engines and the N memory.
//   req_EVP/req_EVB          : engine requests for the read port
//   rd_addr_N_EVP/_EVB       : engine read addresses
//   gnt_EVP/gnt_EVB          : registered ownership grants
//   rd_en_N/rd_addr_N        : N memory read command
//   rd_data_N                : N memory read data (1-cycle latency)
//   rd_data, valid_EVP/_EVB  : returned data and its owning engine
// modport master : the arbiter
// modport slave  : engines + memory side
interface n_rd_arbiter_if #(
  parameter int unsigned n_size    = 8,
  parameter int unsigned word_size = 16
);
  // log2 with log2(1) = 1 so a single-entry memory still has a 1-bit address
  localparam int unsigned AW = (n_size <= 2) ? 1 : $clog2(n_size);

  logic                 req_EVP;
  logic [AW-1:0]        rd_addr_N_EVP;
  logic                 req_EVB;
  logic [AW-1:0]        rd_addr_N_EVB;
  logic                 gnt_EVP;
  logic                 gnt_EVB;
  logic                 rd_en_N;
  logic [AW-1:0]        rd_addr_N;
  logic [word_size-1:0] rd_data_N;
  logic [word_size-1:0] rd_data;
  logic                 valid_EVP;
  logic                 valid_EVB;

  modport master (
    input  req_EVP, rd_addr_N_EVP, req_EVB, rd_addr_N_EVB, rd_data_N,
    output gnt_EVP, gnt_EVB, rd_en_N, rd_addr_N, rd_data, valid_EVP, valid_EVB
  );

  modport slave (
    output req_EVP, rd_addr_N_EVP, req_EVB, rd_addr_N_EVB, rd_data_N,
    input  gnt_EVP, gnt_EVB, rd_en_N, rd_addr_N, rd_data, valid_EVP, valid_EVB
  );
endinterface

// File: rtl/n_rd_arbiter.sv
// Round-robin arbiter sharing the N memory read port between EVP and EVB.
// Grants are registered, bursts are bounded by max_burst while the other
// engine waits, and returned data is tagged to the engine that issued it.
//   clk   : system clock
//   rst   : synchronous active-high reset
//   instr : decoded instruction (0 STP, 1 EVP, 2 EVB, 3 RST, other = STP)
//   bus   : request/grant/read bus (see n_rd_arbiter_if)
module n_rd_arbiter #(
  parameter int unsigned n_size    = 8,
  parameter int unsigned word_size = 16,
  parameter int unsigned max_burst = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           instr,
  n_rd_arbiter_if.master       bus
);
  localparam int unsigned AW = (n_size <= 2) ? 1 : $clog2(n_size);
  localparam logic [3:0] BURST_MAX  = 4'(max_burst);
  localparam logic [3:0] BURST_LAST = 4'(max_burst - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN_EVP = 2'd1, OWN_EVB = 2'd2} state_t;
  typedef enum logic {EVP = 1'b0, EVB = 1'b1} owner_t;

  state_t        state, state_nx;
  owner_t        last_owner;
  logic [3:0]    burst_cnt;
  logic          valid_evp_q, valid_evb_q;
  logic          op_stp, op_rst;
  logic          gnt_evp, gnt_evb, rd_en;
  logic [AW-1:0] rd_addr;

  always_comb begin
    op_rst = (instr == 8'd3);
    op_stp = !((instr == 8'd1) || (instr == 8'd2) || (instr == 8'd3));
  end

  always_comb begin
    gnt_evp = (state == OWN_EVP);
    gnt_evb = (state == OWN_EVB);
    rd_en   = (gnt_evp & bus.req_EVP) | (gnt_evb & bus.req_EVB);
    rd_addr = '0;
    if (rd_en) rd_addr = gnt_evp ? bus.rd_addr_N_EVP : bus.rd_addr_N_EVB;
  end

  // STP also suppresses burst-limit handoff: it blocks any new grant,
  // so the current owner keeps the port until its request drops.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (!op_stp) begin
          if (bus.req_EVP && bus.req_EVB)
            state_nx = (last_owner == EVB) ? OWN_EVP : OWN_EVB;
          else if (bus.req_EVP)
            state_nx = OWN_EVP;
          else if (bus.req_EVB)
            state_nx = OWN_EVB;
        end
      end
      OWN_EVP: begin
        if (!bus.req_EVP)
          state_nx = (bus.req_EVB && !op_stp) ? OWN_EVB : IDLE;
        else if (burst_cnt == BURST_LAST && rd_en && bus.req_EVB && !op_stp)
          state_nx = OWN_EVB;
      end
      OWN_EVB: begin
        if (!bus.req_EVB)
          state_nx = (bus.req_EVP && !op_stp) ? OWN_EVP : IDLE;
        else if (burst_cnt == BURST_LAST && rd_en && bus.req_EVP && !op_stp)
          state_nx = OWN_EVP;
      end
      default: state_nx = IDLE;
    endcase
  end

  // The RST instruction shares the reset path; a read issued in that cycle
  // still reaches the memory but its return is never tagged.
  always_ff @(posedge clk) begin
    if (rst || op_rst) begin
      state       <= IDLE;
      last_owner  <= EVB;
      burst_cnt   <= '0;
      valid_evp_q <= 1'b0;
      valid_evb_q <= 1'b0;
    end else begin
      state       <= state_nx;
      valid_evp_q <= rd_en & gnt_evp;
      valid_evb_q <= rd_en & gnt_evb;
      if (state_nx != state) begin
        burst_cnt <= '0;
        if (state_nx == OWN_EVP) last_owner <= EVP;
        if (state_nx == OWN_EVB) last_owner <= EVB;
      end else if (rd_en && burst_cnt != BURST_MAX) begin
        burst_cnt <= burst_cnt + 4'd1;
      end
    end
  end

  assign bus.gnt_EVP   = gnt_evp;
  assign bus.gnt_EVB   = gnt_evb;
  assign bus.rd_en_N   = rd_en;
  assign bus.rd_addr_N = rd_addr;
  assign bus.rd_data   = bus.rd_data_N[word_size-1:0];
  assign bus.valid_EVP = valid_evp_q;
  assign bus.valid_EVB = valid_evb_q;
endmodule

// File: tb/tb_n_rd_arbiter.sv
// Bench for n_rd_arbiter: two instances (n_size=8/max_burst=4 and
// n_size=1/max_burst=1) driven with the same requests and checked every
// cycle against a cycle-level reference model of the arbitration rules.
module tb_n_rd_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] instr;
  always #5 clk = ~clk;

  n_rd_arbiter_if #(.n_size(8), .word_size(16)) bus_a ();
  n_rd_arbiter_if #(.n_size(1), .word_size(16)) bus_b ();

  n_rd_arbiter #(.n_size(8), .word_size(16), .max_burst(4)) dut_a (
    .clk(clk), .rst(rst), .instr(instr), .bus(bus_a));
  n_rd_arbiter #(.n_size(1), .word_size(16), .max_burst(1)) dut_b (
    .clk(clk), .rst(rst), .instr(instr), .bus(bus_b));

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // owner: 0 nobody, 1 EVP, 2 EVB; last: 1 or 2; cnt: reads in current tenure
  typedef struct {
    int owner;
    int last;
    int cnt;
    bit ve;
    bit vb;
  } ref_t;

  ref_t m_a, m_b;
  logic [15:0] data_a, data_b;

  function automatic ref_t ref_reset();
    ref_t r;
    r.owner = 0; r.last = 2; r.cnt = 0; r.ve = 0; r.vb = 0;
    return r;
  endfunction

  function automatic ref_t advance(ref_t s, bit reset, int ins, bit re, bit rq, int mb);
    ref_t n;
    bit   stp, rd, mine, theirs;
    int   nxt;
    n   = s;
    nxt = s.owner;
    stp = !(ins == 1 || ins == 2 || ins == 3);
    rd  = (s.owner == 1 && re) || (s.owner == 2 && rq);
    if (reset || ins == 3) return ref_reset();
    if (s.owner == 0) begin
      if (!stp) begin
        if (re && rq) nxt = 3 - s.last;
        else if (re)  nxt = 1;
        else if (rq)  nxt = 2;
      end
    end else begin
      mine   = (s.owner == 1) ? re : rq;
      theirs = (s.owner == 1) ? rq : re;
      if (!mine) nxt = (theirs && !stp) ? 3 - s.owner : 0;
      else if (s.cnt == mb - 1 && theirs && !stp) nxt = 3 - s.owner;
    end
    n.ve = rd && s.owner == 1;
    n.vb = rd && s.owner == 2;
    if (nxt != s.owner) begin
      n.cnt = 0;
      if (nxt != 0) n.last = nxt;
    end else if (rd && s.cnt < mb) begin
      n.cnt = s.cnt + 1;
    end
    n.owner = nxt;
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // One clock: apply requests, check outputs mid-cycle, advance the model,
  // then present the memory's response to whatever read was issued.
  task automatic tick(input bit re, input bit rq, input logic [2:0] ae, input logic [2:0] ab);
    bit rd_a, rd_b;
    int adr_a;
    bus_a.req_EVP = re; bus_a.req_EVB = rq;
    bus_a.rd_addr_N_EVP = ae; bus_a.rd_addr_N_EVB = ab;
    bus_b.req_EVP = re; bus_b.req_EVB = rq;
    bus_b.rd_addr_N_EVP = 1'b0; bus_b.rd_addr_N_EVB = 1'b0;
    @(negedge clk);
    rd_a  = (m_a.owner == 1 && re) || (m_a.owner == 2 && rq);
    adr_a = !rd_a ? 0 : (m_a.owner == 1 ? int'(ae) : int'(ab));
    rd_b  = (m_b.owner == 1 && re) || (m_b.owner == 2 && rq);
    chk("a.gnt_EVP",   32'(bus_a.gnt_EVP),   32'(m_a.owner == 1));
    chk("a.gnt_EVB",   32'(bus_a.gnt_EVB),   32'(m_a.owner == 2));
    chk("a.rd_en_N",   32'(bus_a.rd_en_N),   32'(rd_a));
    chk("a.rd_addr_N", 32'(bus_a.rd_addr_N), 32'(adr_a));
    chk("a.valid_EVP", 32'(bus_a.valid_EVP), 32'(m_a.ve));
    chk("a.valid_EVB", 32'(bus_a.valid_EVB), 32'(m_a.vb));
    chk("a.rd_data",   32'(bus_a.rd_data),   32'(data_a));
    chk("b.gnt_EVP",   32'(bus_b.gnt_EVP),   32'(m_b.owner == 1));
    chk("b.gnt_EVB",   32'(bus_b.gnt_EVB),   32'(m_b.owner == 2));
    chk("b.rd_en_N",   32'(bus_b.rd_en_N),   32'(rd_b));
    chk("b.rd_addr_N", 32'(bus_b.rd_addr_N), 32'd0);
    chk("b.valid_EVP", 32'(bus_b.valid_EVP), 32'(m_b.ve));
    chk("b.valid_EVB", 32'(bus_b.valid_EVB), 32'(m_b.vb));
    chk("b.rd_data",   32'(bus_b.rd_data),   32'(data_b));
    @(posedge clk);
    m_a = advance(m_a, rst, int'(instr), re, rq, 4);
    m_b = advance(m_b, rst, int'(instr), re, rq, 1);
    #1;
    data_a = rd_a ? 16'(10 * adr_a) : 16'($urandom);
    data_b = rd_b ? 16'(16'h0100 + cyc) : 16'($urandom);
    bus_a.rd_data_N = data_a;
    bus_b.rd_data_N = data_b;
    cyc++;
  endtask

  initial begin
    int r;
    m_a = ref_reset();
    m_b = ref_reset();
    rst = 1'b1;
    instr = 8'd1;
    data_a = '0; data_b = '0;
    bus_a.rd_data_N = '0; bus_b.rd_data_N = '0;
    bus_a.req_EVP = 1'b1; bus_a.req_EVB = 1'b1;
    bus_a.rd_addr_N_EVP = '0; bus_a.rd_addr_N_EVB = '0;
    bus_b.req_EVP = 1'b1; bus_b.req_EVB = 1'b1;
    bus_b.rd_addr_N_EVP = '0; bus_b.rd_addr_N_EVB = '0;
    @(posedge clk); #1;

    // Reset with both requests high, then tie goes to EVP
    tick(1, 1, 3'd1, 3'd2);
    tick(1, 1, 3'd1, 3'd2);
    rst = 1'b0;
    tick(1, 1, 3'd1, 3'd2);
    tick(1, 1, 3'd1, 3'd2);
    tick(0, 0, 3'd0, 3'd0);
    tick(0, 0, 3'd0, 3'd0);

    // Single EVP stream, addresses 0..5 once granted
    for (int i = 0; i < 7; i++) tick(1, 0, 3'((i == 0) ? 0 : i - 1), 3'd0);
    tick(0, 0, 3'd0, 3'd0);
    tick(0, 0, 3'd0, 3'd0);

    // Contention: both streaming
    for (int i = 0; i < 16; i++) tick(1, 1, 3'($urandom), 3'($urandom));
    tick(0, 0, 3'd0, 3'd0);
    tick(0, 0, 3'd0, 3'd0);

    // STP gating
    tick(1, 0, 3'd4, 3'd0);
    tick(1, 0, 3'd5, 3'd0);
    instr = 8'd0;
    for (int i = 0; i < 6; i++) tick(1, 1, 3'(i), 3'd6);
    for (int i = 0; i < 3; i++) tick(0, 1, 3'd0, 3'd6);
    instr = 8'd2;
    for (int i = 0; i < 3; i++) tick(0, 1, 3'd0, 3'(i));
    tick(0, 0, 3'd0, 3'd0);
    tick(0, 0, 3'd0, 3'd0);

    // RST instruction during the third EVP read
    instr = 8'd1;
    tick(1, 0, 3'd1, 3'd0);
    tick(1, 0, 3'd1, 3'd0);
    tick(1, 0, 3'd2, 3'd0);
    instr = 8'd3;
    tick(1, 0, 3'd3, 3'd0);
    instr = 8'd1;
    tick(1, 1, 3'd4, 3'd5);
    tick(1, 1, 3'd4, 3'd5);
    tick(0, 0, 3'd0, 3'd0);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      r = $urandom_range(0, 19);
      if (r < 2)       instr = 8'd0;
      else if (r < 9)  instr = 8'd1;
      else if (r < 17) instr = 8'd2;
      else if (r < 18) instr = 8'd3;
      else             instr = 8'($urandom_range(4, 255));
      rst = ($urandom_range(0, 59) == 0);
      tick($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           3'($urandom), 3'($urandom));
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
